// File: rtl/hyper_arb_pkg.sv
// Shared types and constants for the HyperRAM request arbiter.
package hyper_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  localparam int DWORD_W = 32;
  localparam int BE_W    = 4;

  // Width of a counter that must hold the value busy_to-1.
  function automatic int cnt_width(input int busy_to);
    return (busy_to <= 2) ? 1 : $clog2(busy_to);
  endfunction

endpackage

// File: rtl/hyper_rr_pick.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping modulo N_REQ.
module hyper_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  // Walk the offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % N_REQ]) begin
        grant_idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyper_req_arbiter.sv
// Shares one hyper_xface controller between N_REQ single-dword requesters,
// granting round-robin and sequencing each access through to a one-cycle ack.
module hyper_req_arbiter
  import hyper_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = DWORD_W,
  parameter int BUSY_TO = 16
) (
  input  logic                    clk,
  input  logic                    reset_l,
  // Handshake: req_valid[i] and its fields are held stable until req_ack[i]
  // pulses for one cycle; the requester drops req_valid the cycle after.
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ*BE_W-1:0]   req_be,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    req_err,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    ctl_rd_req,
  output logic                    ctl_wr_req,
  output logic [ADDR_W-1:0]       ctl_addr,
  output logic [DATA_W-1:0]       ctl_wr_d,
  output logic [BE_W-1:0]         ctl_wr_byte_en,
  input  logic [DATA_W-1:0]       ctl_rd_d,
  input  logic                    ctl_rd_rdy,
  input  logic                    ctl_busy,
  output logic [2:0]              dbg_state
);

  localparam int IDX_W = (N_REQ <= 2) ? 1 : $clog2(N_REQ);
  localparam int CNT_W = cnt_width(BUSY_TO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  hyper_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !ctl_busy) begin
          idx_d    = pick_idx;
          we_d     = req_we[pick_idx];
          addr_d   = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d  = req_wdata[pick_idx*DATA_W +: DATA_W];
          be_d     = req_be[pick_idx*BE_W +: BE_W];
          rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          err_d    = 1'b0;
          cap_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (ctl_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (ctl_rd_rdy && !we_q) cap_d = ctl_rd_d;
        // rd_rdy may coincide with busy falling; cap_d already carries that data.
        if (!ctl_busy) begin
          rdata_d = we_q ? '0 : cap_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      cap_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    req_ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ack[i] = (state_q == ST_DONE) && (idx_q == IDX_W'(i));
    end
  end

  assign req_err        = (state_q == ST_DONE) && err_q;
  assign req_rdata      = rdata_q;
  assign ctl_wr_req     = (state_q == ST_ISSUE) && we_q;
  assign ctl_rd_req     = (state_q == ST_ISSUE) && !we_q;
  assign ctl_addr       = addr_q;
  assign ctl_wr_d       = wdata_q;
  assign ctl_wr_byte_en = be_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_hyper_req_arbiter.sv
// Directed bench for hyper_req_arbiter with a small hyper_xface controller model.
module tb_hyper_req_arbiter;
  import hyper_arb_pkg::*;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BUSY_TO = 16;
  localparam int AW      = 4 + 1 + 32 + 8;
  localparam int SW      = 1 + 32 + 32 + 4;
  localparam logic [31:0] JUNK = 32'hBAD0_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  logic                    clk;
  logic                    reset_l;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*4-1:0]      req_be;
  logic [N_REQ-1:0]        req_ack;
  logic                    req_err;
  logic [DATA_W-1:0]       req_rdata;
  logic                    ctl_rd_req;
  logic                    ctl_wr_req;
  logic [ADDR_W-1:0]       ctl_addr;
  logic [DATA_W-1:0]       ctl_wr_d;
  logic [3:0]              ctl_wr_byte_en;
  logic [DATA_W-1:0]       ctl_rd_d;
  logic                    ctl_rd_rdy;
  logic                    ctl_busy;
  logic [2:0]              dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int model_mode = 0;  // 0 normal, 1 never busy, 2 rd_rdy with busy fall

  logic [AW-1:0] exp_ack_q[$];
  logic [SW-1:0] exp_str_q[$];
  txn_t          port_q[N_REQ][$];
  logic [31:0]   mem[logic [31:0]];

  hyper_req_arbiter #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk            (clk),
    .reset_l        (reset_l),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .req_ack        (req_ack),
    .req_err        (req_err),
    .req_rdata      (req_rdata),
    .ctl_rd_req     (ctl_rd_req),
    .ctl_wr_req     (ctl_wr_req),
    .ctl_addr       (ctl_addr),
    .ctl_wr_d       (ctl_wr_d),
    .ctl_wr_byte_en (ctl_wr_byte_en),
    .ctl_rd_d       (ctl_rd_d),
    .ctl_rd_rdy     (ctl_rd_rdy),
    .ctl_busy       (ctl_busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input bit want_ack);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    exp_str_q.push_back(t);
    if (want_ack) exp_ack_q.push_back({4'(port), err, rdata, 8'(lat)});
    port_q[port].push_back(t);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_ack_q.size() != 0 || exp_str_q.size() != 0 || port_q[0].size() != 0 ||
            port_q[1].size() != 0 || req_valid != '0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: transactions still pending after %0d cycles (acks left %0d)",
               name, n, exp_ack_q.size());
      exp_ack_q.delete(); exp_str_q.delete(); port_q[0].delete(); port_q[1].delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int n;
    n = 0;
    while (dbg_state != st && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 128'(dbg_state), 128'(st));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   128'(req_ack), 128'(0));
    check({tag, "_err"},   128'(req_err), 128'(0));
    check({tag, "_rdata"}, 128'(req_rdata), 128'(0));
    check({tag, "_strb"},  128'({ctl_rd_req, ctl_wr_req}), 128'(0));
    check({tag, "_addr"},  128'(ctl_addr), 128'(0));
    check({tag, "_wd"},    128'(ctl_wr_d), 128'(0));
    check({tag, "_be"},    128'(ctl_wr_byte_en), 128'(0));
    check({tag, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
  endtask

  // ---------------- requester driver ----------------
  initial begin
    txn_t t;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (!reset_l || req_ack[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && port_q[i].size() > 0) begin
          t = port_q[i].pop_front();
          req_valid[i]                   = 1'b1;
          req_we[i]                      = t.we;
          req_addr[i*ADDR_W +: ADDR_W]   = t.addr;
          req_wdata[i*DATA_W +: DATA_W]  = t.wdata;
          req_be[i*4 +: 4]               = t.be;
        end
      end
    end
  end

  // ---------------- controller model ----------------
  initial begin
    int          mc;
    logic        mact;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] nv;
    mc = 0; mact = 1'b0; mwe = 1'b0; maddr = '0;
    ctl_busy = 1'b0; ctl_rd_rdy = 1'b0; ctl_rd_d = JUNK;
    forever begin
      @(negedge clk);
      ctl_rd_rdy = 1'b0;
      ctl_rd_d   = JUNK;
      if (!reset_l) begin
        mact = 1'b0;
        ctl_busy = 1'b0;
      end else if (mact) begin
        mc++;
        if (mc == 1) ctl_busy = 1'b1;
        if (mc == 3 && !mwe) begin
          ctl_rd_d   = mem_rd(maddr);
          ctl_rd_rdy = 1'b1;
          if (model_mode == 2) begin
            ctl_busy = 1'b0;
            mact = 1'b0;
          end
        end
        if (mc == 4) begin
          ctl_busy = 1'b0;
          mact = 1'b0;
        end
      end else if ((ctl_wr_req || ctl_rd_req) && model_mode != 1) begin
        mact = 1'b1; mc = 0; mwe = ctl_wr_req; maddr = ctl_addr;
        if (ctl_wr_req) begin
          nv = mem_rd(ctl_addr);
          for (int b = 0; b < 4; b++) if (ctl_wr_byte_en[b]) nv[8*b +: 8] = ctl_wr_d[8*b +: 8];
          mem[ctl_addr] = nv;
        end
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ctl_wr_req || ctl_rd_req) begin
        check("strobe_while_busy", 128'(ctl_busy), 128'(0));
        check("strobe_both", 128'(ctl_wr_req && ctl_rd_req), 128'(0));
        check("strobe_width", 128'(prev), 128'(0));
        if (exp_str_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected: wr %0b rd %0b addr %0h with none pending",
                   ctl_wr_req, ctl_rd_req, ctl_addr);
        end else begin
          check("strobe_fields", 128'({ctl_wr_req, ctl_addr, ctl_wr_d, ctl_wr_byte_en}),
                128'(exp_str_q.pop_front()));
        end
        strobe_cyc = cyc;
      end
      prev = ctl_wr_req || ctl_rd_req;
    end
  end

  initial begin
    logic [3:0] idx;
    forever begin
      @(posedge clk); #1;
      if (req_ack != '0) begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) if (req_ack[i]) idx = 4'(i);
        check("ack_onehot", 128'($onehot(req_ack)), 128'(1));
        if (exp_ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack_unexpected: ack %b with no pending request", req_ack);
        end else begin
          check("ack_idx_err_rdata_lat", 128'({idx, req_err, req_rdata, 8'(cyc - strobe_cyc)}),
                128'(exp_ack_q.pop_front()));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_l = 1'b1;

    // single write, then read it back from the other port
    issue(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    wait_drain("single_write");
    issue(1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 5, 1'b1);
    wait_drain("read_back");

    // both ports contending: grants alternate 0,1,0,1
    issue(0, 1'b1, 32'h104, 32'h1111_1111, 4'h3, 1'b0, 32'h0, 5, 1'b1);
    issue(1, 1'b1, 32'h10C, 32'h3333_3333, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    issue(0, 1'b1, 32'h108, 32'h2222_2222, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    issue(1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 32'h0000_1111, 5, 1'b1);
    wait_drain("contention");

    // controller never goes busy: error ack, rdata cleared, then normal write
    model_mode = 1;
    issue(0, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1, 32'h0, 17, 1'b1);
    wait_drain("timeout");
    model_mode = 0;
    issue(0, 1'b1, 32'h200, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    wait_drain("after_timeout");

    // rd_rdy and busy fall together
    model_mode = 2;
    issue(1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 4, 1'b1);
    wait_drain("same_cycle_rdy");
    model_mode = 0;

    // reset while waiting for completion: no ack, everything clears at once
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'h0, 0, 1'b0);
    wait_state(ST_WAIT_DONE, "reach_wait_done");
    reset_l = 1'b0;
    #1;
    check_all_zero("mid_reset");
    port_q[0].delete();
    port_q[1].delete();
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    // rr pointer back at 0: port 0 wins first
    issue(0, 1'b1, 32'h300, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    issue(1, 1'b1, 32'h304, 32'h9ABC_DEF0, 4'hF, 1'b0, 32'h0, 5, 1'b1);
    wait_drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
